// File: rtl/bfu_pipe_if.sv
// ---------------------------------------------------------------------------
// bfu_pipe_if
// Handshake and data bundle for the NTT/INTT butterfly pipeline.
//   in_valid / in_ready    : input beat handshake
//   mode                   : 00 CT, 01 GS, 10 GS_HALF, 11 behaves as GS
//   a, b, w                : operands and twiddle, canonical [0,Q)
//   tag_in                 : sideband tag (coefficient address)
//   out_valid / out_ready  : result beat handshake
//   y1, y2, tag_out        : results and the tag that travelled with them
// master = beat producer / result consumer, slave = the butterfly unit.
// ---------------------------------------------------------------------------
interface bfu_pipe_if #(
  parameter int unsigned DATA_W = 32'd16,
  parameter int unsigned TAG_W  = 32'd8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] w;
  logic [TAG_W-1:0]  tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] y1;
  logic [DATA_W-1:0] y2;
  logic [TAG_W-1:0]  tag_out;

  modport master (
    output in_valid, mode, a, b, w, tag_in, out_ready,
    input  in_ready, out_valid, y1, y2, tag_out
  );

  modport slave (
    input  in_valid, mode, a, b, w, tag_in, out_ready,
    output in_ready, out_valid, y1, y2, tag_out
  );
endinterface

// File: rtl/bfu_pipe.sv
// ---------------------------------------------------------------------------
// bfu_pipe
// Three-stage pipelined modular butterfly (CT forward, GS inverse, GS with
// divide-by-2). All results are fully reduced to [0,Q).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : bfu_pipe_if.slave (input beat, result beat, sideband tag)
// Stage plan:
//   S1 : operand capture
//   S2 : CT -> w*b mod Q ; GS -> (a+b) mod Q and (a-b) mod Q
//   S3 : CT -> a +/- t   ; GS -> sum and diff*w mod Q, optional halving
// One global advance signal stalls every stage at once when the output
// register holds a beat that downstream has not taken.
// ---------------------------------------------------------------------------
module bfu_pipe #(
  parameter int unsigned DATA_W = 32'd16,
  parameter int unsigned Q      = 32'd3329,
  parameter int unsigned TAG_W  = 32'd8
) (
  input logic       clk,
  input logic       rst,
  bfu_pipe_if.slave bus
);

  // Modulus must be odd (halving needs an inverse of 2) and fit DATA_W.
  if (((Q % 32'd2) == 32'd0) || (Q >= (32'd1 << DATA_W))) begin : g_bad_q
    $error("bfu_pipe: Q must be odd and below 2**DATA_W");
  end

  localparam logic [1:0] MODE_CT      = 2'b00;
  localparam logic [1:0] MODE_GS_HALF = 2'b10;

  localparam logic [DATA_W:0]     Q_X    = (DATA_W + 32'd1)'(Q);
  localparam logic [2*DATA_W-1:0] Q_WIDE = (2 * DATA_W)'(Q);

  // (x + y) mod Q for canonical x, y
  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= Q_X) ? DATA_W'(s - Q_X) : DATA_W'(s);
  endfunction

  // (x - y) mod Q; equal operands give 0, never Q
  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic [DATA_W:0] d;
    if (x >= y) begin
      d = {1'b0, x} - {1'b0, y};
    end else begin
      d = {1'b0, x} + Q_X - {1'b0, y};
    end
    return DATA_W'(d);
  endfunction

  // (x * y) mod Q with the full double-width product
  function automatic logic [DATA_W-1:0] mod_mul(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic [2*DATA_W-1:0] p;
    p = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
    return DATA_W'(p % Q_WIDE);
  endfunction

  // x * 2^-1 mod Q: odd values borrow Q to become even first
  function automatic logic [DATA_W-1:0] mod_half(input logic [DATA_W-1:0] x);
    logic [DATA_W:0] t;
    if (x[0]) begin
      t = {1'b0, x} + Q_X;
    end else begin
      t = {1'b0, x};
    end
    return DATA_W'(t >> 1);
  endfunction

  logic              adv_s;

  logic              v1_r;
  logic [1:0]        mode1_r;
  logic [DATA_W-1:0] a1_r;
  logic [DATA_W-1:0] b1_r;
  logic [DATA_W-1:0] w1_r;
  logic [TAG_W-1:0]  tag1_r;

  logic              v2_r;
  logic [1:0]        mode2_r;
  logic [DATA_W-1:0] x2_r;   // CT: a        GS: (a+b) mod Q
  logic [DATA_W-1:0] p2_r;   // CT: w*b mod Q GS: (a-b) mod Q
  logic [DATA_W-1:0] w2_r;
  logic [TAG_W-1:0]  tag2_r;

  logic              v3_r;
  logic [DATA_W-1:0] y1_r;
  logic [DATA_W-1:0] y2_r;
  logic [TAG_W-1:0]  tag3_r;

  logic [DATA_W-1:0] x2_s;
  logic [DATA_W-1:0] p2_s;
  logic [DATA_W-1:0] y1_s;
  logic [DATA_W-1:0] y2_s;

  // The pipeline moves only when the output slot is empty or being taken.
  assign adv_s        = !(v3_r && !bus.out_ready);
  assign bus.in_ready = adv_s;
  assign bus.out_valid = v3_r;
  assign bus.y1        = y1_r;
  assign bus.y2        = y2_r;
  assign bus.tag_out   = tag3_r;

  // Stage-2 datapath: modular multiply for CT, add/sub for GS.
  always_comb begin
    x2_s = a1_r;
    p2_s = '0;
    case (mode1_r)
      MODE_CT: begin
        x2_s = a1_r;
        p2_s = mod_mul(w1_r, b1_r);
      end
      default: begin
        x2_s = mod_add(a1_r, b1_r);
        p2_s = mod_sub(a1_r, b1_r);
      end
    endcase
  end

  // Stage-3 datapath: final add/sub for CT, twiddle product and halving for GS.
  always_comb begin
    y1_s = x2_r;
    y2_s = '0;
    case (mode2_r)
      MODE_CT: begin
        y1_s = mod_add(x2_r, p2_r);
        y2_s = mod_sub(x2_r, p2_r);
      end
      MODE_GS_HALF: begin
        y1_s = mod_half(x2_r);
        y2_s = mod_half(mod_mul(p2_r, w2_r));
      end
      default: begin
        y1_s = x2_r;
        y2_s = mod_mul(p2_r, w2_r);
      end
    endcase
  end

  // Stage 1: capture operands; a low in_valid on advance becomes a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_r    <= 1'b0;
      mode1_r <= 2'b00;
      a1_r    <= '0;
      b1_r    <= '0;
      w1_r    <= '0;
      tag1_r  <= '0;
    end else if (adv_s) begin
      v1_r    <= bus.in_valid;
      mode1_r <= bus.mode;
      a1_r    <= bus.a;
      b1_r    <= bus.b;
      w1_r    <= bus.w;
      tag1_r  <= bus.tag_in;
    end
  end

  // Stage 2: register first-level results together with mode, twiddle, tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v2_r    <= 1'b0;
      mode2_r <= 2'b00;
      x2_r    <= '0;
      p2_r    <= '0;
      w2_r    <= '0;
      tag2_r  <= '0;
    end else if (adv_s) begin
      v2_r    <= v1_r;
      mode2_r <= mode1_r;
      x2_r    <= x2_s;
      p2_r    <= p2_s;
      w2_r    <= w1_r;
      tag2_r  <= tag1_r;
    end
  end

  // Stage 3: output register; data only reloads for a valid beat so the
  // visible outputs stay quiet across bubbles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v3_r   <= 1'b0;
      y1_r   <= '0;
      y2_r   <= '0;
      tag3_r <= '0;
    end else if (adv_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        y1_r   <= y1_s;
        y2_r   <= y2_s;
        tag3_r <= tag2_r;
      end
    end
  end

endmodule

// File: tb/tb_bfu_pipe.sv
// ---------------------------------------------------------------------------
// tb_bfu_pipe
// Directed corner beats, a randomized 64-beat stream with backpressure and a
// mid-stream reset, checked against an integer reference of the butterfly.
// ---------------------------------------------------------------------------
module tb_bfu_pipe;
  localparam int DW = 16;
  localparam int TW = 8;
  localparam int QM = 3329;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bfu_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

  bfu_pipe #(.DATA_W(DW), .Q(QM), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int y1;
    int y2;
    int tg;
  } exp_t;
  exp_t exp_q[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mod_q(input int x);
    return ((x % QM) + QM) % QM;
  endfunction

  function automatic int half_q(input int x);
    return (x % 2 == 0) ? x / 2 : (x + QM) / 2;
  endfunction

  // Butterfly reference straight from the arithmetic definitions.
  task automatic ref_bfu(input int m, input int a, input int b, input int w,
                         output int y1, output int y2);
    int t;
    if (m == 0) begin
      t  = mod_q(w * b);
      y1 = mod_q(a + t);
      y2 = mod_q(a - t);
    end else begin
      y1 = mod_q(a + b);
      y2 = mod_q(mod_q(a - b) * w);
      if (m == 2) begin
        y1 = half_q(y1);
        y2 = half_q(y2);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int m, input int a, input int b, input int w, input int tg);
    bus.mode   = 2'(m);
    bus.a      = 16'(a);
    bus.b      = 16'(b);
    bus.w      = 16'(w);
    bus.tag_in = 8'(tg);
  endtask

  // Single beat with out_ready high; measures cycles from acceptance.
  task automatic directed(input string name, input int m, input int a, input int b,
                          input int w, input int tg, input int e1, input int e2);
    int lat;
    drive_beat(m, a, b, w, tg);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check_eq({name, "_in_ready"}, int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_eq({name, "_latency"}, lat, 3);
    check_eq({name, "_y1"}, int'(bus.y1), e1);
    check_eq({name, "_y2"}, int'(bus.y2), e2);
    check_eq({name, "_tag"}, int'(bus.tag_out), tg);
    tick();
    #1;
  endtask

  initial begin
    int sent;
    int got;
    int cyc;
    int m, a, b, w;
    int r1, r2;
    logic prev_stall;
    int py1, py2, ptg;
    exp_t e;

    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive_beat(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_y1", int'(bus.y1), 0);
    check_eq("rst_y2", int'(bus.y2), 0);
    check_eq("rst_tag", int'(bus.tag_out), 0);
    check_eq("rst_in_ready", int'(bus.in_ready), 1);
    tick();

    // Directed corner beats
    directed("ct_basic", 0, 100, 200, 17, 8'h11, 171, 29);
    directed("gs_basic", 1, 100, 200, 17, 8'h5A, 300, 1629);
    directed("gs_equal", 1, 5, 5, 1000, 8'h22, 10, 0);
    directed("ct_max", 0, 3328, 3328, 3328, 8'h33, 0, 3327);
    directed("gs_half", 2, 3, 0, 1, 8'h44, 1666, 1666);
    ref_bfu(3, 1234, 2999, 777, r1, r2);
    directed("mode3_as_gs", 3, 1234, 2999, 777, 8'h55, r1, r2);

    // Randomized stream with a fixed stall window then random backpressure
    sent = 0;
    got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    py1 = 0;
    py2 = 0;
    ptg = 0;
    while ((sent < 64 || exp_q.size() != 0 || bus.out_valid) && cyc < 3000) begin
      if (cyc < 10) bus.out_ready = 1'b1;
      else if (cyc <= 14) bus.out_ready = 1'b0;
      else bus.out_ready = 1'($urandom_range(0, 1));
      if (sent < 64) begin
        m = int'($urandom_range(0, 3));
        a = int'($urandom_range(0, QM - 1));
        b = int'($urandom_range(0, QM - 1));
        w = int'($urandom_range(0, QM - 1));
        drive_beat(m, a, b, w, sent);
        bus.in_valid = ($urandom_range(0, 4) != 0);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      check_eq("stall_rule", int'(bus.in_ready), int'(!(bus.out_valid && !bus.out_ready)));
      if (prev_stall) begin
        check_eq("hold_valid", int'(bus.out_valid), 1);
        check_eq("hold_y1", int'(bus.y1), py1);
        check_eq("hold_y2", int'(bus.y2), py2);
        check_eq("hold_tag", int'(bus.tag_out), ptg);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", int'(bus.tag_out), -1);
        end else begin
          e = exp_q.pop_front();
          check_eq("stream_y1", int'(bus.y1), e.y1);
          check_eq("stream_y2", int'(bus.y2), e.y2);
          check_eq("stream_tag", int'(bus.tag_out), e.tg);
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        ref_bfu(m, a, b, w, r1, r2);
        e.y1 = r1;
        e.y2 = r2;
        e.tg = sent % 256;
        exp_q.push_back(e);
        sent++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      py1 = int'(bus.y1);
      py2 = int'(bus.y2);
      ptg = int'(bus.tag_out);
      tick();
      cyc++;
    end
    check_eq("stream_no_timeout", int'(cyc < 3000), 1);
    check_eq("stream_count", got, 64);

    // Reset with three beats in flight and the output stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(0, 10 + i, 20 + i, 30 + i, 8'hA0 + i);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    check_eq("pre_rst_valid", int'(bus.out_valid), 1);
    check_eq("pre_rst_in_ready", int'(bus.in_ready), 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", int'(bus.out_valid), 0);
    check_eq("mid_rst_y1", int'(bus.y1), 0);
    check_eq("mid_rst_y2", int'(bus.y2), 0);
    check_eq("mid_rst_tag", int'(bus.tag_out), 0);
    check_eq("mid_rst_in_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_rst_no_beat", int'(bus.out_valid), 0);
    end
    ref_bfu(0, 1234, 2345, 3000, r1, r2);
    directed("post_rst_fresh", 0, 1234, 2345, 3000, 8'h7E, r1, r2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bfu_pipe.md
Name: bfu_pipe

Overview:
- Parametrised, pipelined modular butterfly unit for the NTT/INTT polynomial-multiplication datapath.
- Serves both transform directions from one instance:
  - Cooley-Tukey forward butterfly.
  - Gentleman-Sande inverse butterfly.
  - Inverse butterfly with built-in divide-by-2 scaling, so the INTT needs no final scaling pass.
- Sits between coefficient RAM read ports and write-back.
- Uses a valid/ready handshake and carries a sideband tag (coefficient address) alongside the data.

Parameters:
- DATA_W, 16, coefficient/twiddle width; Q must satisfy Q < 2^DATA_W.
- Q, 3329, odd modulus. Elaboration error if Q is even or Q >= 2^DATA_W.
- TAG_W, 8, width of the sideband tag passed through unchanged.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- mode  in  2  operation select: 00 CT, 01 GS, 10 GS_HALF, 11 reserved (treated as GS).
- a  in  DATA_W  upper operand, canonical [0,Q).
- b  in  DATA_W  lower operand, canonical [0,Q).
- w  in  DATA_W  twiddle factor, canonical [0,Q).
- tag_in  in  TAG_W  sideband tag.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- y1  out  DATA_W  first result.
- y2  out  DATA_W  second result.
- tag_out  out  TAG_W  tag aligned with y1/y2.

Behaviour:
- Arithmetic. All results are fully reduced to [0,Q). Q itself is never emitted.
  - CT: y1 = (a + w*b) mod Q; y2 = (a - w*b) mod Q.
  - GS: y1 = (a + b) mod Q; y2 = ((a - b) mod Q) * w mod Q.
  - GS_HALF: both GS results are halved mod Q. half(x) = x/2 if x is even, else (x+Q)/2.
  - Subtraction: when a == b, the difference is 0, not Q.
  - Products are full 2*DATA_W wide before reduction. No intermediate truncation.
  - Out-of-range inputs (>= Q): results unspecified, no hang.
- Pipeline.
  - Three register stages: S1 captures the operands, S2 does multiply/reduce or add/sub, S3 does the final add/sub and optional halving.
  - Latency is exactly 3 cycles from an accepted beat to out_valid, with no stalls.
  - Throughput is 1 beat per cycle.
  - Each stage holds a valid bit. mode and tag travel with the data.
- Handshake.
  - A beat is accepted when in_valid && in_ready on a clk edge.
  - A beat is retired when out_valid && out_ready.
  - Global stall: in_ready = !(out_valid && !out_ready). While stalled, every stage holds its contents.
  - y1, y2 and tag_out stay stable while out_valid && !out_ready.
  - Bubbles propagate: in_valid low during an advance produces an invalid S1.
  - in_ready has no combinational dependence on in_valid.
  - Simultaneous accept and retire in the same cycle is permitted and loses no data.
- Reset (rst == 0 at a clk edge), regardless of in-flight data:
  - All stage valid bits clear, so out_valid = 0.
  - y1 = 0, y2 = 0, tag_out = 0.
  - in_ready = 1 from the first cycle after reset.
  - Beats in flight are discarded. No partial beat emerges after reset.
- Order. Results leave in acceptance order. No reordering.

Test Plan:
- CT, Q=3329: a=100, b=200, w=17 -> y1=171, y2=29, out_valid asserted exactly 3 cycles after accept.
- GS: a=100, b=200, w=17, tag=0x5A -> y1=300, y2=1629, tag_out=0x5A. Then a=b=5, w=1000 -> y1=10, y2=0 (never 3329).
- Boundary CT: a=b=w=3328 -> y1=0, y2=3327. GS_HALF: a=3, b=0, w=1 -> y1=1666, y2=1666.
- Back-to-back stream:
  - Stimulus: 64 random canonical beats with mixed modes, out_ready held low for cycles 10-14 and toggled randomly afterwards.
  - Required: all results match the model, in order. No drop or duplicate.
  - Required: in_ready = 0 exactly while out_valid && !out_ready; outputs stable during the stall.
- Reset mid-stream: assert rst low with 3 beats in flight and out_ready=0 -> next cycle out_valid=0, y1=y2=tag_out=0, in_ready=1. A fresh beat then emerges after 3 cycles with the correct value.
